xor_arbiter_puf: RTL and testbench

XOR_ARBITER_PUF -- requirements
Module: xor_arbiter_puf

---
 rtl/xor_arbiter_puf.sv | 225 ++++++++++++++++++++++
 tb/tb_xor_arbiter_puf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_arbiter_puf.sv
// XOR arbiter PUF: N_CHAINS crossed-mux delay chains raced by a common pulse, each
// chain's arbiter bit majority-voted over N_EVAL evaluations and the votes XORed.
module xor_arbiter_puf #(
    parameter int unsigned C_LENGTH      = 8,
    parameter int unsigned N_CHAINS      = 4,
    parameter int unsigned N_EVAL        = 5,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                istart,
    input  logic [C_LENGTH-1:0] ichallenge,
    input  logic                itest_en,
    input  logic [N_CHAINS-1:0] itest_bits,
    output logic                obusy,
    output logic                ovalid,
    output logic                oresponse,
    output logic [N_CHAINS-1:0] oraw,
    output logic                ostable
);

    // Counter widths: ones/eval counters hold 0..N_EVAL, phase counter 0..SETTLE_CYCLES-1
    localparam int unsigned CW = $clog2(N_EVAL + 1);
    localparam int unsigned PW = $clog2(SETTLE_CYCLES);

    localparam logic [CW-1:0] EVAL_LAST  = CW'(N_EVAL - 1);
    localparam logic [CW-1:0] MAJ_THR    = CW'((N_EVAL + 1) / 2);
    localparam logic [CW-1:0] EVAL_ALL   = CW'(N_EVAL);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StFire,
        StCapture,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [PW-1:0]       r_phase;
    logic [PW-1:0]       w_phase_next;
    logic [CW-1:0]       r_eval;
    logic [CW-1:0]       w_eval_next;
    logic [CW-1:0]       r_ones [N_CHAINS];
    logic [CW-1:0]       w_ones_next [N_CHAINS];
    logic [C_LENGTH-1:0] r_chal;
    logic [C_LENGTH-1:0] w_chal_next;
    logic                r_pulse;

    logic [N_CHAINS-1:0] w_arb;
    logic [N_CHAINS-1:0] r_sync1;
    logic [N_CHAINS-1:0] r_sync2;
    logic [N_CHAINS-1:0] w_sample;
    logic [N_CHAINS-1:0] w_maj;
    logic [N_CHAINS-1:0] w_unan;

    logic                r_valid;
    logic                r_resp;
    logic [N_CHAINS-1:0] r_raw;
    logic                r_stable;

    // Delay chains and arbiters; chain k sees the challenge rotated left by k
    for (genvar k = 0; k < N_CHAINS; k++) begin : g_chain
        localparam int unsigned ROT = k % C_LENGTH;

        logic [C_LENGTH-1:0] w_sel;
        logic                w_top;
        logic                w_bot;
        logic                r_arb;

        if (ROT == 0) begin : g_rot0
            assign w_sel = r_chal;
        end else begin : g_rot
            assign w_sel = {r_chal[C_LENGTH-1-ROT:0], r_chal[C_LENGTH-1:C_LENGTH-ROT]};
        end

        // Walk the pulse through each stage, swapping the lines where the select is 1
        always_comb begin
            logic v_top;
            logic v_bot;
            logic v_tmp;
            v_top = r_pulse;
            v_bot = r_pulse;
            v_tmp = 1'b0;
            for (int i = 0; i < C_LENGTH; i++) begin
                if (w_sel[i]) begin
                    v_tmp = v_top;
                    v_top = v_bot;
                    v_bot = v_tmp;
                end
            end
            w_top = v_top;
            w_bot = v_bot;
        end

        // Race arbiter: bottom line already high when top rises gives a 1; no reset by design
        always_ff @(posedge w_top) begin
            r_arb <= w_bot;
        end

        assign w_arb[k] = r_arb;
    end

    // Two-flop synchroniser bringing the asynchronous arbiter bits into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_arb;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = itest_en ? itest_bits : r_sync2;

    // Per-chain majority vote and unanimity from the ones counters
    always_comb begin
        w_maj  = '0;
        w_unan = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            w_maj[k]  = (r_ones[k] >= MAJ_THR);
            w_unan[k] = (r_ones[k] == '0) || (r_ones[k] == EVAL_ALL);
        end
    end

    // Next-state and counter updates for the ARM/FIRE/CAPTURE evaluation loop
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_eval_next  = r_eval;
        w_chal_next  = r_chal;
        w_ones_next  = r_ones;
        unique case (r_state)
            StIdle: begin
                if (istart) begin
                    w_chal_next  = ichallenge;
                    w_phase_next = '0;
                    w_eval_next  = '0;
                    for (int k = 0; k < N_CHAINS; k++) begin
                        w_ones_next[k] = '0;
                    end
                    w_state_next = StArm;
                end
            end
            StArm: begin
                if (r_phase == PHASE_LAST) begin
                    w_phase_next = '0;
                    w_state_next = StFire;
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            StFire: begin
                if (r_phase == PHASE_LAST) begin
                    w_phase_next = '0;
                    w_state_next = StCapture;
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            StCapture: begin
                for (int k = 0; k < N_CHAINS; k++) begin
                    w_ones_next[k] = r_ones[k] + CW'(w_sample[k]);
                end
                w_eval_next  = r_eval + 1'b1;
                w_state_next = (r_eval == EVAL_LAST) ? StDone : StArm;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, counters, latched challenge and the race pulse (aligned with the FIRE state)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_phase <= '0;
            r_eval  <= '0;
            r_chal  <= '0;
            r_pulse <= 1'b0;
            for (int k = 0; k < N_CHAINS; k++) begin
                r_ones[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_eval  <= w_eval_next;
            r_chal  <= w_chal_next;
            r_pulse <= (w_state_next == StFire);
            for (int k = 0; k < N_CHAINS; k++) begin
                r_ones[k] <= w_ones_next[k];
            end
        end
    end

    // Result registers: loaded in DONE, held until the next DONE; ovalid follows DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_raw    <= '0;
            r_resp   <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_valid <= (r_state == StDone);
            if (r_state == StDone) begin
                r_raw    <= w_maj;
                r_resp   <= ^w_maj;
                r_stable <= &w_unan;
            end
        end
    end

    assign obusy     = (r_state != StIdle);
    assign ovalid    = r_valid;
    assign oraw      = r_raw;
    assign oresponse = r_resp;
    assign ostable   = r_stable;

endmodule

// File: tb/tb_xor_arbiter_puf.sv
// Self-checking bench: per-cycle comparison against a timing/voting model, plus
// directed scenarios with hand-computed expectations and a small second instance.
module tb_xor_arbiter_puf;

    localparam int unsigned CL = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned NE = 5;
    localparam int unsigned SC = 4;
    localparam int P = 2 * SC + 1;   // cycles per evaluation
    localparam int L = NE * P;       // cycles of evaluations per request

    logic          clk = 1'b0;
    logic          rst;
    logic          istart;
    logic [CL-1:0] ichallenge;
    logic          itest_en;
    logic [NC-1:0] itest_bits;
    logic          obusy;
    logic          ovalid;
    logic          oresponse;
    logic [NC-1:0] oraw;
    logic          ostable;

    logic          istart1;
    logic [7:0]    ichallenge1;
    logic          itest_en1;
    logic [0:0]    itest_bits1;
    logic          obusy1;
    logic          ovalid1;
    logic          oresponse1;
    logic [0:0]    oraw1;
    logic          ostable1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit            m_busy;
    int            m_t;
    int            m_ones [NC];
    logic [NC-1:0] m_raw;
    bit            m_resp;
    bit            m_stable;
    bit            m_valid;
    bit            m_pulse;

    // Stimulus control for the capture-cycle test bits
    int            bits_mode;   // 0 random, 1 fixed, 2 per-evaluation sequence
    logic [NC-1:0] fixed_bits;
    logic [NC-1:0] seq_bits [NE];

    xor_arbiter_puf #(
        .C_LENGTH     (CL),
        .N_CHAINS     (NC),
        .N_EVAL       (NE),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .istart    (istart),
        .ichallenge(ichallenge),
        .itest_en  (itest_en),
        .itest_bits(itest_bits),
        .obusy     (obusy),
        .ovalid    (ovalid),
        .oresponse (oresponse),
        .oraw      (oraw),
        .ostable   (ostable)
    );

    xor_arbiter_puf #(
        .C_LENGTH     (8),
        .N_CHAINS     (1),
        .N_EVAL       (1),
        .SETTLE_CYCLES(3)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .istart    (istart1),
        .ichallenge(ichallenge1),
        .itest_en  (itest_en1),
        .itest_bits(itest_bits1),
        .obusy     (obusy1),
        .ovalid    (ovalid1),
        .oresponse (oresponse1),
        .oraw      (oraw1),
        .ostable   (ostable1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every edge, then compare all outputs just after the edge
    initial begin
        m_busy = 0; m_t = 0; m_raw = '0; m_resp = 0; m_stable = 0; m_valid = 0; m_pulse = 0;
        foreach (m_ones[k]) m_ones[k] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_valid = 0; m_raw = '0; m_resp = 0; m_stable = 0;
            end else begin
                m_valid = 0;
                if (!m_busy) begin
                    if (istart) begin
                        m_busy = 1;
                        m_t = 0;
                        foreach (m_ones[k]) m_ones[k] = 0;
                    end
                end else begin
                    m_t++;
                    if (m_t <= L && m_t % P == 0) begin
                        foreach (m_ones[k]) m_ones[k] += int'(itest_bits[k]);
                    end
                    if (m_t == L + 1) begin
                        m_busy = 0;
                        m_valid = 1;
                        m_stable = 1;
                        foreach (m_ones[k]) begin
                            m_raw[k] = (m_ones[k] >= (NE + 1) / 2);
                            if (m_ones[k] != 0 && m_ones[k] != NE) m_stable = 0;
                        end
                        m_resp = ^m_raw;
                    end
                end
            end
            m_pulse = m_busy && m_t < L && (m_t % P) >= SC && (m_t % P) < 2 * SC;
            #1;
            check("obusy", obusy, m_busy);
            check("ovalid", ovalid, m_valid);
            check("pulse", dut.r_pulse, m_pulse);
            check("oraw", oraw, m_raw);
            check("oresponse", oresponse, m_resp);
            check("ostable", ostable, m_stable);
        end
    end

    // Test-bit driver: test mode forced on for each capture edge, random elsewhere
    initial begin
        itest_en = 1'b1;
        itest_bits = '0;
        forever begin
            @(negedge clk);
            if (m_busy && (m_t + 1) % P == 0 && m_t + 1 <= L) begin
                itest_en = 1'b1;
                case (bits_mode)
                    0: itest_bits = NC'($urandom);
                    1: itest_bits = fixed_bits;
                    default: itest_bits = seq_bits[m_t / P];
                endcase
            end else begin
                itest_en = 1'($urandom);
                itest_bits = NC'($urandom);
            end
        end
    end

    // One request: optional extra istart pulse or reset at cycle c after acceptance
    task automatic run_request(input int pulse_at, input int rst_at, output int lat,
                               output int nvalid, output logic [NC-1:0] raw,
                               output logic resp, output logic stable,
                               output logic busy_rst, output logic pulse_rst);
        lat = 0; nvalid = 0; raw = '0; resp = 0; stable = 0; busy_rst = 1; pulse_rst = 1;
        @(negedge clk);
        istart = 1'b1;
        ichallenge = CL'($urandom);
        @(negedge clk);
        istart = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            if (ovalid) begin
                nvalid++;
                if (lat == 0) begin
                    lat = c; raw = oraw; resp = oresponse; stable = ostable;
                end
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                busy_rst = obusy;
                pulse_rst = dut.r_pulse;
            end
            @(negedge clk);
            ichallenge = CL'($urandom);
            istart = (c == pulse_at);
            rst = (rst_at > 0 && c == rst_at);
        end
        istart = 1'b0;
        rst = 1'b0;
    endtask

    initial begin : main
        int            lat;
        int            nv;
        logic [NC-1:0] raw;
        logic          resp;
        logic          stable;
        logic          brst;
        logic          prst;

        rst = 1'b1; istart = 1'b0; ichallenge = '0;
        bits_mode = 0; fixed_bits = '0;
        foreach (seq_bits[i]) seq_bits[i] = '0;
        istart1 = 1'b0; ichallenge1 = '0; itest_en1 = 1'b1; itest_bits1 = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_obusy", obusy, 0);
        check("reset_oraw", oraw, 0);
        check("reset_pulse", dut.r_pulse, 0);
        check("reset_dut1_ovalid", ovalid1, 0);
        rst = 1'b0;

        // Fixed bits 1011 in every evaluation
        bits_mode = 1; fixed_bits = 4'b1011;
        run_request(0, 0, lat, nv, raw, resp, stable, brst, prst);
        check("lat_1011", lat, 46);
        check("raw_1011", raw, 4'b1011);
        check("resp_1011", resp, 1);
        check("stable_1011", stable, 1);

        // Per-evaluation sequence: chain 0 votes 3 of 5
        bits_mode = 2;
        seq_bits[0] = 4'b0001; seq_bits[1] = 4'b0001; seq_bits[2] = 4'b0000;
        seq_bits[3] = 4'b0001; seq_bits[4] = 4'b0000;
        run_request(0, 0, lat, nv, raw, resp, stable, brst, prst);
        check("lat_seq", lat, 46);
        check("raw_seq", raw, 4'b0001);
        check("resp_seq", resp, 1);
        check("stable_seq", stable, 0);

        // Extra istart while busy is dropped
        bits_mode = 0;
        run_request(10, 0, lat, nv, raw, resp, stable, brst, prst);
        check("busy_pulse_nvalid", nv, 1);
        check("busy_pulse_lat", lat, 46);
        repeat (5) @(negedge clk);
        check("busy_pulse_idle", obusy, 0);

        // Reset mid-request aborts with no result
        run_request(0, 20, lat, nv, raw, resp, stable, brst, prst);
        check("rst_nvalid", nv, 0);
        check("rst_busy", brst, 0);
        check("rst_pulse", prst, 0);

        // Reset together with istart is not an acceptance
        @(negedge clk); rst = 1'b1; istart = 1'b1;
        @(negedge clk); rst = 1'b0; istart = 1'b0;
        check("rst_start_idle", obusy, 0);
        repeat (2) @(negedge clk);
        check("rst_start_still_idle", obusy, 0);

        bits_mode = 1; fixed_bits = 4'b1111;
        run_request(0, 0, lat, nv, raw, resp, stable, brst, prst);
        check("lat_1111", lat, 46);
        check("raw_1111", raw, 4'b1111);
        check("resp_1111", resp, 0);
        check("stable_1111", stable, 1);
        check("model_raw_1111", m_raw, 4'b1111);

        // istart held high: back-to-back requests every 47 cycles
        bits_mode = 0;
        @(negedge clk); istart = 1'b1;
        nv = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (ovalid) nv++;
        end
        @(negedge clk); istart = 1'b0;
        check("held_nvalid", nv, 4);
        repeat (60) @(negedge clk);

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            istart = ($urandom_range(0, 7) == 0);
            ichallenge = CL'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk); istart = 1'b0; rst = 1'b0;
        repeat (60) @(negedge clk);

        // Single chain, single evaluation, three-cycle phases
        for (int t = 0; t < 2; t++) begin
            itest_bits1 = (t == 0) ? 1'b1 : 1'b0;
            @(negedge clk); istart1 = 1'b1; ichallenge1 = 8'($urandom);
            @(negedge clk); istart1 = 1'b0;
            lat = 0; nv = 0; resp = 0; stable = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                if (ovalid1) begin
                    nv++;
                    if (lat == 0) begin
                        lat = c; resp = oresponse1; stable = ostable1; raw[0] = oraw1[0];
                    end
                end
            end
            check("dut1_lat", lat, 8);
            check("dut1_nvalid", nv, 1);
            check("dut1_resp", resp, (t == 0) ? 1 : 0);
            check("dut1_raw_eq_resp", raw[0], resp);
            check("dut1_stable", stable, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
